// File: rtl/rgmii_rx_framer.sv
// RGMII receive frame controller: preamble/SFD strip, frame delimiting, length checks.
// Optional per-frame statistics counters are built when RGMII_RX_STATS_EN is defined.
module rgmii_rx_framer #(
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1522,
  parameter int unsigned PRE_MIN = 2,
  parameter int unsigned STAT_W  = 32
) (
  input  logic              rx_rgmii_clk,
  input  logic              rx_rst_n,
  input  logic              rx_data_valid,
  input  logic              rx_data_error,
  input  logic [7:0]        rx_data_in,
  output logic [7:0]        m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  output logic              m_axis_tuser,
  output logic [15:0]       frame_len,
  output logic [STAT_W-1:0] stat_frames_ok,
  output logic [STAT_W-1:0] stat_frames_bad,
  output logic [STAT_W-1:0] stat_pre_err
);

  localparam logic [15:0] MIN_LEN_W = 16'(MIN_LEN);
  localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);
  localparam logic [3:0]  PRE_MIN_W = 4'(PRE_MIN);

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_PAY, S_DROP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  pre_cnt_q, pre_cnt_d;
  logic [15:0] len_q, len_d;
  logic        bad_q, bad_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_vld_q, hold_vld_d;
  logic [7:0]  tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d;
  logic        tlast_q, tlast_d;
  logic        tuser_q, tuser_d;
  logic [15:0] frame_len_q, frame_len_d;
  logic        pre_err;
  logic        empty_frame;

  logic dv, er;
  assign dv = rx_data_valid;
  assign er = rx_data_valid ^ rx_data_error;

  always_comb begin
    state_d     = state_q;
    pre_cnt_d   = pre_cnt_q;
    len_d       = len_q;
    bad_d       = bad_q;
    hold_d      = hold_q;
    hold_vld_d  = hold_vld_q;
    tdata_d     = tdata_q;
    tvalid_d    = 1'b0;
    tlast_d     = 1'b0;
    tuser_d     = 1'b0;
    frame_len_d = frame_len_q;
    pre_err     = 1'b0;
    empty_frame = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        hold_vld_d = 1'b0;
        if (dv) begin
          if (rx_data_in == 8'h55) begin
            state_d   = S_PRE;
            pre_cnt_d = 4'd1;
          end else begin
            state_d = S_DROP;
            pre_err = 1'b1;
          end
        end
      end

      S_PRE: begin
        if (!dv) begin
          state_d = S_IDLE;
          pre_err = 1'b1;
        end else if (rx_data_in == 8'h55) begin
          if (pre_cnt_q != 4'hF) pre_cnt_d = pre_cnt_q + 4'd1;
        end else if (rx_data_in == 8'hD5 && pre_cnt_q >= PRE_MIN_W) begin
          state_d    = S_PAY;
          len_d      = '0;
          bad_d      = 1'b0;
          hold_vld_d = 1'b0;
        end else begin
          state_d = S_DROP;
          pre_err = 1'b1;
        end
      end

      S_PAY: begin
        // One-byte hold register lets the final byte carry tlast without lookahead,
        // giving the same two-cycle latency for every byte.
        if (dv) begin
          if (len_q == MAX_LEN_W) begin
            tvalid_d    = 1'b1;
            tdata_d     = hold_q;
            tlast_d     = 1'b1;
            tuser_d     = 1'b1;
            frame_len_d = len_q;
            hold_vld_d  = 1'b0;
            state_d     = S_DROP;
          end else begin
            len_d      = len_q + 16'd1;
            bad_d      = bad_q | er;
            hold_d     = rx_data_in;
            hold_vld_d = 1'b1;
            if (hold_vld_q) begin
              tvalid_d    = 1'b1;
              tdata_d     = hold_q;
              frame_len_d = len_q;
            end
          end
        end else begin
          if (hold_vld_q) begin
            tvalid_d    = 1'b1;
            tdata_d     = hold_q;
            tlast_d     = 1'b1;
            tuser_d     = bad_q | (len_q < MIN_LEN_W);
            frame_len_d = len_q;
          end else begin
            empty_frame = 1'b1;
          end
          hold_vld_d = 1'b0;
          state_d    = S_IDLE;
        end
      end

      S_DROP: begin
        if (!dv) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge rx_rgmii_clk) begin
    if (!rx_rst_n) begin
      state_q     <= S_IDLE;
      pre_cnt_q   <= '0;
      len_q       <= '0;
      bad_q       <= 1'b0;
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tuser_q     <= 1'b0;
      frame_len_q <= '0;
    end else begin
      state_q     <= state_d;
      pre_cnt_q   <= pre_cnt_d;
      len_q       <= len_d;
      bad_q       <= bad_d;
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      tuser_q     <= tuser_d;
      frame_len_q <= frame_len_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;
  assign frame_len     = frame_len_q;

`ifdef RGMII_RX_STATS_EN
  logic [STAT_W-1:0] ok_cnt_q, ok_cnt_d;
  logic [STAT_W-1:0] bad_cnt_q, bad_cnt_d;
  logic [STAT_W-1:0] pre_cnt_err_q, pre_cnt_err_d;

  always_comb begin
    ok_cnt_d      = ok_cnt_q;
    bad_cnt_d     = bad_cnt_q;
    pre_cnt_err_d = pre_cnt_err_q;
    if (tvalid_d && tlast_d && !tuser_d) ok_cnt_d = ok_cnt_q + STAT_W'(1);
    if ((tvalid_d && tlast_d && tuser_d) || empty_frame) bad_cnt_d = bad_cnt_q + STAT_W'(1);
    if (pre_err) pre_cnt_err_d = pre_cnt_err_q + STAT_W'(1);
  end

  always_ff @(posedge rx_rgmii_clk) begin
    if (!rx_rst_n) begin
      ok_cnt_q      <= '0;
      bad_cnt_q     <= '0;
      pre_cnt_err_q <= '0;
    end else begin
      ok_cnt_q      <= ok_cnt_d;
      bad_cnt_q     <= bad_cnt_d;
      pre_cnt_err_q <= pre_cnt_err_d;
    end
  end

  assign stat_frames_ok  = ok_cnt_q;
  assign stat_frames_bad = bad_cnt_q;
  assign stat_pre_err    = pre_cnt_err_q;
`else
  logic stats_unused;
  assign stats_unused    = ^{pre_err, empty_frame};
  assign stat_frames_ok  = '0;
  assign stat_frames_bad = '0;
  assign stat_pre_err    = '0;
`endif

endmodule

// File: tb/tb_rgmii_rx_framer.sv
// Randomized bench for rgmii_rx_framer with a burst-level reference model.
module tb_rgmii_rx_framer;

  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1522;
  localparam int PRE_MIN = 2;
  localparam int STAT_W  = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              dv = 1'b0;
  logic              derr = 1'b0;
  logic [7:0]        din = '0;
  logic [7:0]        m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tlast;
  logic              m_axis_tuser;
  logic [15:0]       frame_len;
  logic [STAT_W-1:0] stat_frames_ok;
  logic [STAT_W-1:0] stat_frames_bad;
  logic [STAT_W-1:0] stat_pre_err;

  rgmii_rx_framer #(
    .MIN_LEN(MIN_LEN),
    .MAX_LEN(MAX_LEN),
    .PRE_MIN(PRE_MIN),
    .STAT_W (STAT_W)
  ) dut (
    .rx_rgmii_clk   (clk),
    .rx_rst_n       (rst_n),
    .rx_data_valid  (dv),
    .rx_data_error  (derr),
    .rx_data_in     (din),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tuser   (m_axis_tuser),
    .frame_len      (frame_len),
    .stat_frames_ok (stat_frames_ok),
    .stat_frames_bad(stat_frames_bad),
    .stat_pre_err   (stat_pre_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         edge_i;
    logic [7:0] data;
    bit         last;
    bit         user;
    int         len;
  } beat_t;

  beat_t      expq[$];
  logic [7:0] bq[$];
  bit         be[$];
  int         edge_n = 0;
  int         exp_ok = 0, exp_bad = 0, exp_pre = 0;
  int         n_vec = 0, n_err = 0;
  bit         mon_en = 1'b0;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  // Every cycle after reset: either the next expected beat or silence.
  always @(negedge clk) begin
    if (mon_en) begin
      if (expq.size() > 0 && expq[0].edge_i == edge_n) begin
        beat_t b;
        b = expq.pop_front();
        chk("beat_tvalid", 32'(m_axis_tvalid), 32'(1));
        chk("beat_tdata", 32'(m_axis_tdata), 32'(b.data));
        chk("beat_tlast", 32'(m_axis_tlast), 32'(b.last));
        if (b.last) begin
          chk("last_tuser", 32'(m_axis_tuser), 32'(b.user));
          chk("last_frame_len", 32'(frame_len), 32'(b.len));
        end
      end else begin
        chk("idle_tvalid", 32'(m_axis_tvalid), 32'(0));
        chk("idle_tlast", 32'(m_axis_tlast), 32'(0));
      end
    end
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation time limit reached, got edge %0d expected finish", edge_n);
    $fatal(1);
  end

  task automatic cyc_drive(input bit v, input bit e, input logic [7:0] d);
    @(posedge clk);
    #1;
    dv   = v;
    derr = v ? ~e : 1'($urandom_range(0, 1));
    din  = v ? d : 8'($urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc_drive(1'b0, 1'b0, 8'h00);
  endtask

  // Classify one dv burst (bq[first..]) from the framing rules; byte k is sampled at
  // first_edge + (k - first) and its output appears one edge later.
  task automatic model_burst(input int first, input int first_edge);
    int  n, l, e;
    bit  user;
    n = first;
    while (n < bq.size() && bq[n] == 8'h55) n++;
    if (n >= bq.size() || bq[n] != 8'hD5 || (n - first) < PRE_MIN) begin
      exp_pre++;
      return;
    end
    l = bq.size() - n - 1;
    if (l == 0) begin
      exp_bad++;
      return;
    end
    e    = (l > MAX_LEN) ? MAX_LEN : l;
    user = (l > MAX_LEN) || (e < MIN_LEN);
    for (int i = 0; i < e; i++) user = user | be[n + 1 + i];
    for (int i = 0; i < e; i++)
      expq.push_back('{first_edge + (n + 1 + i - first) + 1, bq[n + 1 + i], (i == e - 1), user, e});
    if (user) exp_bad++;
    else exp_ok++;
  endtask

  task automatic build(input int npre, input logic [7:0] sfd, input int plen,
                       input int err_idx, input bit ramp);
    bq.delete();
    be.delete();
    for (int i = 0; i < npre; i++) begin
      bq.push_back(8'h55);
      be.push_back(1'($urandom_range(0, 1)));
    end
    bq.push_back(sfd);
    be.push_back(1'($urandom_range(0, 1)));
    for (int i = 0; i < plen; i++) begin
      bq.push_back(ramp ? 8'(i) : 8'($urandom));
      be.push_back(i == err_idx);
    end
  endtask

  // Drive the built burst followed by one dv=0 cycle; optionally pulse reset on byte rst_at.
  task automatic run_burst(input int rst_at);
    int r_edge;
    for (int i = 0; i < bq.size(); i++) begin
      cyc_drive(1'b1, be[i], bq[i]);
      if (i == 0) model_burst(0, edge_n + 1);
      if (i == rst_at) begin
        rst_n  = 1'b0;
        r_edge = edge_n + 1;
        while (expq.size() > 0 && expq[expq.size() - 1].edge_i >= r_edge) void'(expq.pop_back());
        exp_ok  = 0;
        exp_bad = 0;
        exp_pre = 0;
      end
      if (rst_at >= 0 && i == rst_at + 1) begin
        rst_n = 1'b1;
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'(0));
        chk("rst_tlast", 32'(m_axis_tlast), 32'(0));
        chk("rst_tuser", 32'(m_axis_tuser), 32'(0));
        chk("rst_tdata", 32'(m_axis_tdata), 32'(0));
        chk("rst_frame_len", 32'(frame_len), 32'(0));
        model_burst(i, edge_n + 1);
      end
    end
    idle(1);
  endtask

  task automatic check_stats(input string tag);
    idle(2);
`ifdef RGMII_RX_STATS_EN
    chk({tag, "_ok"}, 32'(stat_frames_ok), 32'(exp_ok));
    chk({tag, "_bad"}, 32'(stat_frames_bad), 32'(exp_bad));
    chk({tag, "_pre"}, 32'(stat_pre_err), 32'(exp_pre));
`else
    chk({tag, "_ok"}, 32'(stat_frames_ok), 32'(0));
    chk({tag, "_bad"}, 32'(stat_frames_bad), 32'(0));
    chk({tag, "_pre"}, 32'(stat_pre_err), 32'(0));
`endif
  endtask

  initial begin
    int npre, plen, err_idx;
    logic [7:0] sfd;

    rst_n = 1'b0;
    idle(3);
    chk("reset_tvalid", 32'(m_axis_tvalid), 32'(0));
    chk("reset_tlast", 32'(m_axis_tlast), 32'(0));
    chk("reset_tuser", 32'(m_axis_tuser), 32'(0));
    chk("reset_tdata", 32'(m_axis_tdata), 32'(0));
    chk("reset_frame_len", 32'(frame_len), 32'(0));
    check_stats("reset");
    rst_n  = 1'b1;
    mon_en = 1'b1;
    idle(2);

    build(7, 8'hD5, 64, -1, 1'b1);  run_burst(-1);  check_stats("good64");
    build(7, 8'hD5, 64, 10, 1'b1);  run_burst(-1);  check_stats("err64");

    build(7, 8'hD5, 20, -1, 1'b0);  run_burst(-1);
    build(1, 8'hD5, 10, -1, 1'b0);  run_burst(-1);
    build(0, 8'hAB, 10, -1, 1'b0);  run_burst(-1);
    build(6, 8'h55, 0, -1, 1'b0);   run_burst(-1);
    build(3, 8'hD5, 0, -1, 1'b0);   run_burst(-1);
    build(2, 8'hD5, 63, -1, 1'b0);  run_burst(-1);
    build(2, 8'hD5, 64, -1, 1'b0);  run_burst(-1);
    build(20, 8'hD5, 70, 69, 1'b0); run_burst(-1);
    check_stats("short_pre");

    build(7, 8'hD5, 1600, -1, 1'b0); run_burst(-1);
    build(7, 8'hD5, 64, -1, 1'b1);   run_burst(-1);
    build(7, 8'hD5, 1522, -1, 1'b0); run_burst(-1);
    build(7, 8'hD5, 1523, -1, 1'b0); run_burst(-1);
    check_stats("maxlen");

    build(7, 8'hD5, 64, -1, 1'b1);  run_burst(-1);
    build(7, 8'hD5, 64, -1, 1'b1);  run_burst(-1);
    check_stats("b2b");

    build(7, 8'hD5, 64, -1, 1'b1);  run_burst(7 + 1 + 30);
    build(7, 8'hD5, 64, -1, 1'b0);  run_burst(-1);
    check_stats("midreset");

    for (int k = 0; k < 40; k++) begin
      npre    = $urandom_range(0, 9);
      sfd     = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'hD5;
      plen    = ($urandom_range(0, 9) == 0) ? $urandom_range(1500, 1530) : $urandom_range(0, 140);
      err_idx = (plen > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, plen - 1) : -1;
      build(npre, sfd, plen, err_idx, 1'b0);
      run_burst(-1);
      idle($urandom_range(0, 2));
    end
    check_stats("random");

    chk("pending_beats", 32'(expq.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
